// File: rtl/rsp_pkt_pkg.sv
// Shared definitions for the read-response packetizer: packet markers,
// word field offsets and the packetizer FSM state type.
package rsp_pkt_pkg;

    localparam logic [7:0] SOP_MARK  = 8'hAA;
    localparam logic [7:0] DATA_MARK = 8'hDD;
    localparam logic [7:0] EOP_MARK  = 8'h53;

    // Field LSB positions within the 128-bit packet word
    localparam int unsigned MARK_LSB  = 120;
    localparam int unsigned RID_LSB   = 116;
    localparam int unsigned RRESP_LSB = 112;
    localparam int unsigned IDX_LSB   = 108;
    localparam int unsigned RDATA_LSB = 76;
    localparam int unsigned EOP_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/rsp_beat_fifo.sv
// First-word-fall-through beat buffer; the caller must not push when full
// unless it pops in the same cycle.
module rsp_beat_fifo #(
    parameter int unsigned WIDTH = 41,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/rd_rsp_packetizer.sv
// Packs AXI read-data beats into header + per-beat data words for the read
// FIFO, with a small beat buffer absorbing FIFO back-pressure.
module rd_rsp_packetizer
    import rsp_pkt_pkg::*;
#(
    parameter int unsigned data_wid  = 32,
    parameter int unsigned id_wid    = 4,
    parameter int unsigned buf_depth = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_rsp_en,
    input  logic [id_wid-1:0]   rid,
    input  logic [data_wid-1:0] rdata,
    input  logic [3:0]          rresp,
    input  logic                rlast,
    input  logic                fifo_full,
    output logic                write_enable,
    output logic [127:0]        fifo_wdata,
    output logic                busy,
    output logic                ovf_err,
    output logic                len_err
);

    localparam int unsigned BW = id_wid + data_wid + 5;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_beat_idx;
    logic [3:0]          w_idx_nxt;
    logic                r_ovf;
    logic                r_len;
    logic                w_len_set;
    logic                w_emit;
    logic                w_pop;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    logic [127:0]        w_word;
    logic [BW-1:0]       w_head;
    logic [id_wid-1:0]   w_h_rid;
    logic [data_wid-1:0] w_h_data;
    logic [3:0]          w_h_resp;
    logic                w_h_last;

    // A full buffer still takes the new beat when the head leaves this cycle
    assign w_push = rd_rsp_en && (!w_full || w_pop);

    rsp_beat_fifo #(
        .WIDTH (BW),
        .DEPTH (buf_depth)
    ) u_beat_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({rid, rdata, rresp, rlast}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_h_rid  = w_head[BW-1 -: id_wid];
    assign w_h_data = w_head[BW-1-id_wid -: data_wid];
    assign w_h_resp = w_head[4:1];
    assign w_h_last = w_head[0];

    // IDLE emits the header itself so it is on the outputs the cycle after the
    // first beat lands; HDR only holds it while the read FIFO is full.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_beat_idx;
        w_emit      = 1'b0;
        w_pop       = 1'b0;
        w_len_set   = 1'b0;
        w_word      = '0;
        case (r_state)
            ST_IDLE, ST_HDR: begin
                if (!w_empty) begin
                    w_emit                   = 1'b1;
                    w_word[MARK_LSB +: 8]    = SOP_MARK;
                    w_word[RID_LSB +: id_wid] = w_h_rid;
                    if (!fifo_full) begin
                        w_state_nxt = ST_DATA;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_HDR;
                    end
                end
            end
            ST_DATA: begin
                if (!w_empty) begin
                    w_emit                       = 1'b1;
                    w_word[MARK_LSB +: 8]        = DATA_MARK;
                    w_word[RID_LSB +: id_wid]    = w_h_rid;
                    w_word[RRESP_LSB +: 4]       = w_h_resp;
                    w_word[IDX_LSB +: 4]         = r_beat_idx;
                    w_word[RDATA_LSB +: data_wid] = w_h_data;
                    w_word[EOP_LSB +: 8]         = w_h_last ? EOP_MARK : 8'h00;
                    if (!fifo_full) begin
                        w_pop     = 1'b1;
                        w_idx_nxt = r_beat_idx + 4'd1;
                        if (w_h_last)
                            w_state_nxt = ST_IDLE;
                        else if (r_beat_idx == 4'd15)
                            w_len_set = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_beat_idx <= '0;
            r_ovf      <= 1'b0;
            r_len      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_idx <= w_idx_nxt;
            if (rd_rsp_en && !w_push) r_ovf <= 1'b1;
            if (w_len_set)            r_len <= 1'b1;
        end
    end

    assign write_enable = w_emit && !fifo_full;
    assign fifo_wdata   = w_word;
    assign busy         = !w_empty || (r_state != ST_IDLE);
    assign ovf_err      = r_ovf;
    assign len_err      = r_len;

endmodule

// File: tb/tb_rd_rsp_packetizer.sv
// Self-checking bench for rd_rsp_packetizer: directed scenarios plus random
// bursts, checked against a packet-level reference model.
module tb_rd_rsp_packetizer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd_rsp_en;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [3:0]   rresp;
    logic         rlast;
    logic         fifo_full;
    logic         write_enable;
    logic [127:0] fifo_wdata;
    logic         busy;
    logic         ovf_err;
    logic         len_err;

    rd_rsp_packetizer #(
        .data_wid  (32),
        .id_wid    (4),
        .buf_depth (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_rsp_en    (rd_rsp_en),
        .rid          (rid),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .fifo_full    (fifo_full),
        .write_enable (write_enable),
        .fifo_wdata   (fifo_wdata),
        .busy         (busy),
        .ovf_err      (ovf_err),
        .len_err      (len_err)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;
    int unsigned we_while_full = 0;

    logic [127:0] got_q[$];
    int unsigned  got_cyc[$];
    logic [127:0] exp_q[$];

    // reference model state: packet open, next beat index, expected len error
    bit       m_open;
    bit [3:0] m_idx;
    bit       m_len;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && write_enable) begin
            got_q.push_back(fifo_wdata);
            got_cyc.push_back(cyc);
        end
        if (rst_n && write_enable && fifo_full) we_while_full++;
    end

    function automatic logic [127:0] hdr_word(input logic [3:0] id);
        logic [127:0] w;
        w = '0;
        w[127:120] = 8'hAA;
        w[119:116] = id;
        return w;
    endfunction

    function automatic logic [127:0] data_word(input logic [3:0] id, input logic [3:0] resp,
                                               input logic [3:0] idx, input logic [31:0] d,
                                               input logic last);
        logic [127:0] w;
        w = '0;
        w[127:120] = 8'hDD;
        w[119:116] = id;
        w[115:112] = resp;
        w[111:108] = idx;
        w[107:76]  = d;
        w[7:0]     = last ? 8'h53 : 8'h00;
        return w;
    endfunction

    task automatic model_beat(input logic [3:0] id, input logic [31:0] d,
                              input logic [3:0] resp, input logic last);
        if (!m_open) begin
            exp_q.push_back(hdr_word(id));
            m_open = 1'b1;
            m_idx  = '0;
        end
        exp_q.push_back(data_word(id, resp, m_idx, d, last));
        if (!last && m_idx == 4'd15) m_len = 1'b1;
        m_idx = m_idx + 4'd1;
        if (last) m_open = 1'b0;
    endtask

    task automatic model_clear();
        m_open = 1'b0;
        m_idx  = '0;
        m_len  = 1'b0;
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    // Drives one beat for one cycle; accepted beats go to the model
    task automatic drive_beat(input logic [3:0] id, input logic [31:0] d,
                              input logic [3:0] resp, input logic last, input bit accept);
        rd_rsp_en = 1'b1;
        rid = id; rdata = d; rresp = resp; rlast = last;
        @(posedge clk); #1;
        rd_rsp_en = 1'b0;
        rlast = 1'b0;
        if (accept) model_beat(id, d, resp, last);
    endtask

    task automatic wait_words(input int unsigned n, output bit to);
        int unsigned k = 0;
        while (got_q.size() < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        to = (got_q.size() < n);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rd_rsp_en = 1'b0; rid = '0; rdata = '0; rresp = '0;
        rlast = 1'b0; fifo_full = 1'b0;
        model_clear();
        #3;
        vectors++;
        if ({write_enable, fifo_wdata, busy, ovf_err, len_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got we=%b wdata=%h busy=%b ovf=%b len=%b, need all 0",
                     write_enable, fifo_wdata, busy, ovf_err, len_err);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({write_enable, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_idle: got we=%b busy=%b, need 0 0", write_enable, busy);
        end
    endtask

    task automatic test_single();
        bit to;
        model_clear();
        drive_beat(4'd3, 32'hDEADBEEF, 4'd0, 1'b1, 1'b1);
        vectors++;
        if (write_enable !== 1'b1 || fifo_wdata !== hdr_word(4'd3)) begin
            miscompares++;
            $display("FAIL single_hdr_latency: got we=%b wdata=%h, need we=1 wdata=%h",
                     write_enable, fifo_wdata, hdr_word(4'd3));
        end
        wait_words(exp_q.size(), to);
        vectors++;
        if (to || got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL single_count: got %0d words, need %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL single_word%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if ({busy, ovf_err, len_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL single_status: got busy=%b ovf=%b len=%b, need 0 0 0", busy, ovf_err, len_err);
        end
    endtask

    task automatic test_burst4();
        bit to;
        model_clear();
        for (int b = 1; b <= 4; b++)
            drive_beat(4'd5, 32'(b), 4'd0, (b == 4), 1'b1);
        wait_words(exp_q.size(), to);
        vectors++;
        if (to || got_q.size() != 5) begin
            miscompares++;
            $display("FAIL burst4_count: got %0d words, need 5", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL burst4_word%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
        if (got_cyc.size() == 5) begin
            vectors++;
            if (got_cyc[4] - got_cyc[0] != 4) begin
                miscompares++;
                $display("FAIL burst4_throughput: got span %0d cycles, need 4", got_cyc[4] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        model_clear();
        we_while_full = 0;
        fifo_full = 1'b1;
        for (int b = 1; b <= 4; b++)
            drive_beat(4'd7, 32'h1000 + 32'(b), 4'(b), (b == 4), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (got_q.size() != 0 || we_while_full != 0) begin
            miscompares++;
            $display("FAIL bp_hold: got %0d pushes while full, need 0", got_q.size() + we_while_full);
        end
        fifo_full = 1'b0;
        wait_words(exp_q.size(), to);
        vectors++;
        if (to || got_q.size() != 5) begin
            miscompares++;
            $display("FAIL bp_count: got %0d words, need 5", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL bp_word%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (ovf_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ovf: got %b, need 0", ovf_err);
        end
    endtask

    task automatic test_len();
        bit to;
        model_clear();
        for (int b = 1; b <= 17; b++)
            drive_beat(4'd4, 32'hA000 + 32'(b), 4'd0, (b == 17), 1'b1);
        // the index-15 beat has not been packed yet, so no wrap so far
        vectors++;
        if (len_err !== 1'b0) begin
            miscompares++;
            $display("FAIL len_early: got %b, need 0", len_err);
        end
        wait_words(exp_q.size(), to);
        vectors++;
        if (to || got_q.size() != 18) begin
            miscompares++;
            $display("FAIL len_count: got %0d words, need 18", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL len_word%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (len_err !== m_len || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL len_flag: got len=%b busy=%b, need len=%b busy=0", len_err, busy, m_len);
        end
    endtask

    task automatic test_overflow();
        bit to;
        apply_reset();
        fifo_full = 1'b1;
        for (int b = 1; b <= 6; b++)
            drive_beat(4'd9, 32'h5500 + 32'(b), 4'd2, (b == 6), (b <= 4));
        vectors++;
        if (ovf_err !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_flag: got %b, need 1", ovf_err);
        end
        fifo_full = 1'b0;
        wait_words(exp_q.size(), to);
        vectors++;
        if (to || got_q.size() != 5) begin
            miscompares++;
            $display("FAIL ovf_count: got %0d words, need 5", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL ovf_word%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (busy !== m_open || ovf_err !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_status: got busy=%b ovf=%b, need busy=%b ovf=1", busy, ovf_err, m_open);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        model_clear();
        for (int b = 1; b <= 8; b++) begin
            drive_beat(4'd6, 32'hC000 + 32'(b), 4'd0, 1'b0, 1'b1);
            if (got_q.size() >= 3) break;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({write_enable, fifo_wdata, busy, ovf_err, len_err} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got we=%b wdata=%h busy=%b ovf=%b len=%b, need all 0",
                     write_enable, fifo_wdata, busy, ovf_err, len_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        drive_beat(4'd2, 32'h0BAD_F00D, 4'd1, 1'b1, 1'b1);
        wait_words(exp_q.size(), to);
        vectors++;
        if (to || got_q.size() != 2) begin
            miscompares++;
            $display("FAIL rstmid_count: got %0d words, need 2", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rstmid_word%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    // Each beat is followed by at least two free cycles, so the buffer can
    // never overflow here even with random fifo_full stalls.
    task automatic test_random();
        bit to;
        logic [31:0] r;
        logic [3:0]  id;
        int unsigned len;
        model_clear();
        for (int p = 0; p < 8; p++) begin
            r  = $urandom;
            id = r[3:0];
            len = $urandom_range(1, 6);
            for (int b = 1; b <= len; b++) begin
                r = $urandom;
                if (r[31:30] == 2'b00) id = r[3:0];
                drive_beat(id, $urandom, r[7:4], (b == len), 1'b1);
                fifo_full = 1'b1;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1 fifo_full = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
        end
        wait_words(exp_q.size(), to);
        vectors++;
        if (to || got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count: got %0d words, need %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rand_word%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if ({busy, ovf_err, len_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL rand_status: got busy=%b ovf=%b len=%b, need 0 0 0", busy, ovf_err, len_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst4();
        test_backpressure();
        test_len();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
